lc2k_data_mem_responder: RTL and testbench
==========================================

// Module: lc2k_data_mem_responder
// PURPOSE
//  Responder side of the LC2K processor's data-memory interface. Accepts one lw/sw
//  request at a time over a valid/ready handshake, inserts programmable wait states,
//  then returns read data or a write acknowledge on a valid/ready response channel.
//  Word-addressed, 32-bit words. Used by the multi-cycle core and as a stall-capable
//  memory model for verification.
// PARAMETERS
//  DATA_LEN    31   MSB index of data/address buses (width = DATA_LEN+1 = 32)
//  MEMDEPTH    200  number of 32-bit words; valid addresses are 0..MEMDEPTH-1
//  WAIT_CYCLES 2    extra cycles between request accept and response (0..15)
// PORTS
//  CLK        in   1   clock; all state updates on rising edge
//  RST        in   1   synchronous reset, active-low (RST==0 at posedge resets)
//  req_valid  in   1   processor presents a request
//  req_ready  out  1   responder can accept a request this cycle
//  req_rw     in   1   1 = write (sw), 0 = read (lw)
//  req_addr   in   32  word address (ALU result)
//  req_wdata  in   32  write data (regB)
//  rsp_valid  out  1   response available
//  rsp_ready  in   1   processor consumes response
//  rsp_rdata  out  32  read data; 0 for write responses
//  rsp_err    out  1   address out of range (only with bounds check compiled in)
// BEHAVIOUR
//  Reset (RST==0 at posedge): state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0,
//   rsp_err=0, wait counter=0. Memory array is NOT cleared. Reset mid-transaction
//   abandons it; a pending write not yet committed is dropped.
//  FSM states: IDLE, WAIT, RESP.
//   IDLE: req_ready=1. On req_valid&&req_ready: latch rw/addr/wdata; counter=WAIT_CYCLES;
//    go WAIT if WAIT_CYCLES>0, else go RESP directly (access performed on this edge).
//   WAIT: req_ready=0. Counter decrements each cycle; at counter==1 perform access and
//    go RESP on that edge.
//   RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_valid&&rsp_ready; then go IDLE.
//    req_ready=0 in RESP (no overlap of response and new accept).
//  Access: read -> rsp_rdata=mem[addr]; write -> mem[addr]=wdata, rsp_rdata=0.
//  Latency: accept edge to rsp_valid high = WAIT_CYCLES+1 cycles. Throughput: one
//   request per WAIT_CYCLES+2 cycles minimum (IDLE cycle required between transactions).
//  req_* inputs ignored outside accept cycle; changes during WAIT/RESP have no effect.
//  Address rule: full 32-bit compare against MEMDEPTH; no modulo wrap. Out-of-range
//   (addr >= MEMDEPTH, incl. negative offsets) read returns 0; write is discarded.
//  rsp_ready held low: responder stays in RESP indefinitely, outputs stable.
//  req_ready is registered-state derived (combinational from state only), not from req_valid.
// CONFIGURATION
//  LC2K_MEM_BOUNDS_CHECK_EN defined: out-of-range access drives rsp_err=1 in RESP
//   (data 0, write discarded); rsp_err=0 for in-range accesses.
//  Not defined: rsp_err tied 0; out-of-range behaviour otherwise identical.
// TESTING
//  T1 reset: RST=0 two cycles with req_valid=1 -> req_ready=0,rsp_valid=0,rsp_rdata=0;
//     RST=1 -> req_ready=1 next cycle.
//  T2 write then read, WAIT_CYCLES=2: sw addr 5 data 0xDEADBEEF -> rsp_valid 3 cycles
//     after accept, rdata 0; lw addr 5 -> rsp_rdata=0xDEADBEEF, latency 3.
//  T3 WAIT_CYCLES=0: lw addr 0 after sw 0x12345678 -> rsp_valid 1 cycle after accept.
//  T4 backpressure: rsp_ready=0 for 5 cycles during lw -> rsp_valid/rdata stable, req_ready=0;
//     rsp_ready=1 -> IDLE next cycle, req_ready=1.
//  T5 bounds: sw addr 200 data 7, then lw addr 199 unchanged and lw addr 0xFFFFFFFF -> 0;
//     rsp_err=1 for out-of-range only when LC2K_MEM_BOUNDS_CHECK_EN defined, else 0.
//  T6 reset mid-op: accept sw addr 3 data 9, assert RST=0 during WAIT -> lw addr 3 returns
//     prior contents (write dropped), FSM back in IDLE.

Source files
------------

// File: rtl/lc2k_data_mem_responder_if.sv
// Request/response bus between the LC2K core and its data-memory responder.
// The core drives the master modport; the memory responder uses the slave modport.
interface lc2k_data_mem_responder_if #(
    parameter int DATA_LEN = 31
);
    logic                req_valid;
    logic                req_ready;
    logic                req_rw;
    logic [DATA_LEN:0]   req_addr;
    logic [DATA_LEN:0]   req_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_LEN:0]   rsp_rdata;
    logic                rsp_err;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lc2k_data_mem_responder.sv
// LC2K data-memory responder: one lw/sw at a time, programmable wait states, held response.
// Define LC2K_MEM_BOUNDS_CHECK_EN to flag out-of-range accesses on rsp_err.
module lc2k_data_mem_responder #(
    parameter int DATA_LEN    = 31,
    parameter int MEMDEPTH    = 200,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    lc2k_data_mem_responder_if.slave    bus
);
    localparam int                AW    = (MEMDEPTH > 1) ? $clog2(MEMDEPTH) : 1;
    localparam logic [DATA_LEN:0] DEPTH = (DATA_LEN + 1)'(MEMDEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t              state, state_next;
    logic [3:0]          cnt, cnt_next;
    logic                running;
    logic                rw_q, rw_next;
    logic [DATA_LEN:0]   addr_q, addr_next;
    logic [DATA_LEN:0]   wdata_q, wdata_next;
    logic [DATA_LEN:0]   rdata_q, rdata_next;
    logic                err_q, err_next;
    logic                req_ready_c;
    logic                do_access;
    logic                acc_rw;
    logic [DATA_LEN:0]   acc_addr;
    logic [DATA_LEN:0]   acc_wdata;
    logic                in_range;
    logic [AW-1:0]       idx;

    logic [DATA_LEN:0]   mem [0:MEMDEPTH-1];

    // With zero wait states the access uses the live request on the accept edge;
    // otherwise it uses the copy latched at accept.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        rw_next     = rw_q;
        addr_next   = addr_q;
        wdata_next  = wdata_q;
        rdata_next  = rdata_q;
        err_next    = err_q;
        do_access   = 1'b0;
        acc_rw      = rw_q;
        acc_addr    = addr_q;
        acc_wdata   = wdata_q;
        req_ready_c = 1'b0;

        case (state)
            ST_IDLE: begin
                req_ready_c = running;
                if (bus.req_valid && running) begin
                    rw_next    = bus.req_rw;
                    addr_next  = bus.req_addr;
                    wdata_next = bus.req_wdata;
                    cnt_next   = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        do_access  = 1'b1;
                        acc_rw     = bus.req_rw;
                        acc_addr   = bus.req_addr;
                        acc_wdata  = bus.req_wdata;
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    do_access  = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        idx      = acc_addr[AW-1:0];
        in_range = (acc_addr < DEPTH);

        if (do_access) begin
            rdata_next = (acc_rw || !in_range) ? '0 : mem[idx];
`ifdef LC2K_MEM_BOUNDS_CHECK_EN
            err_next   = !in_range;
`else
            err_next   = 1'b0;
`endif
        end
    end

    // running holds req_ready low until the first clock edge after reset is released.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            running <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            running <= 1'b1;
            rw_q    <= rw_next;
            addr_q  <= addr_next;
            wdata_q <= wdata_next;
            rdata_q <= rdata_next;
            err_q   <= err_next;
        end
    end

    // Memory contents survive reset, but a write due on a reset edge is dropped.
    always_ff @(posedge CLK) begin
        if (RST && do_access && acc_rw && in_range) begin
            mem[idx] <= acc_wdata;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_lc2k_data_mem_responder.sv
// Scoreboard bench for lc2k_data_mem_responder: a 2-wait-state instance and a 0-wait-state instance.
// Expected err flags follow LC2K_MEM_BOUNDS_CHECK_EN.
module tb_lc2k_data_mem_responder;
`ifdef LC2K_MEM_BOUNDS_CHECK_EN
    localparam logic BC = 1'b1;
`else
    localparam logic BC = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t q2[$];
    exp_t q0[$];
    exp_t cur2, cur0;
    bit   seen2 = 1'b0;
    bit   seen0 = 1'b0;

    lc2k_data_mem_responder_if bus2 ();
    lc2k_data_mem_responder_if bus0 ();

    lc2k_data_mem_responder #(.WAIT_CYCLES(2)) u_dut2 (.CLK(clk), .RST(rst_n), .bus(bus2));
    lc2k_data_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (.CLK(clk), .RST(rst_n), .bus(bus0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop an expectation when a response first appears, then hold it stable until consumed.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            seen2 = 1'b0;
        end else if (bus2.rsp_valid) begin
            check_output("w2_req_ready_in_resp", 32'(bus2.req_ready), 32'd0);
            if (!seen2) begin
                if (q2.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL w2_unexpected_rsp: got rsp_valid=1, expected no response");
                end else begin
                    cur2  = q2.pop_front();
                    seen2 = 1'b1;
                    check_output("w2_rdata", bus2.rsp_rdata, cur2.rdata);
                    check_output("w2_err", 32'(bus2.rsp_err), 32'(cur2.err));
                    check_output("w2_latency_cycle", 32'(cyc), 32'(cur2.due));
                end
            end else begin
                check_output("w2_rdata_stable", bus2.rsp_rdata, cur2.rdata);
                check_output("w2_err_stable", 32'(bus2.rsp_err), 32'(cur2.err));
            end
            if (bus2.rsp_ready) seen2 = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            seen0 = 1'b0;
        end else if (bus0.rsp_valid) begin
            check_output("w0_req_ready_in_resp", 32'(bus0.req_ready), 32'd0);
            if (!seen0) begin
                if (q0.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL w0_unexpected_rsp: got rsp_valid=1, expected no response");
                end else begin
                    cur0  = q0.pop_front();
                    seen0 = 1'b1;
                    check_output("w0_rdata", bus0.rsp_rdata, cur0.rdata);
                    check_output("w0_err", 32'(bus0.rsp_err), 32'(cur0.err));
                    check_output("w0_latency_cycle", 32'(cyc), 32'(cur0.due));
                end
            end else begin
                check_output("w0_rdata_stable", bus0.rsp_rdata, cur0.rdata);
            end
            if (bus0.rsp_ready) seen0 = 1'b0;
        end
    end

    // One full transaction; hold > 0 keeps rsp_ready low for that many response cycles.
    task automatic apply_stimulus(input bit use0, input logic rw, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata_exp,
                                  input logic err_exp, input int hold);
        int   n;
        int   k;
        bit   ok;
        exp_t e;
        @(posedge clk); #1;
        if (use0) begin
            bus0.req_valid = 1'b1; bus0.req_rw = rw; bus0.req_addr = addr;
            bus0.req_wdata = wdata; bus0.rsp_ready = (hold == 0);
        end else begin
            bus2.req_valid = 1'b1; bus2.req_rw = rw; bus2.req_addr = addr;
            bus2.req_wdata = wdata; bus2.rsp_ready = (hold == 0);
        end
        n = 0; ok = 1'b0;
        while (n < 50 && !ok) begin
            @(negedge clk);
            ok = use0 ? bus0.req_ready : bus2.req_ready;
            n++;
        end
        if (!ok) begin
            tests++; fails++;
            $display("[TB] FAIL accept_timeout: got req_ready=0 for 50 cycles, expected 1");
            bus0.req_valid = 1'b0; bus2.req_valid = 1'b0;
            bus0.rsp_ready = 1'b1; bus2.rsp_ready = 1'b1;
            return;
        end
        @(posedge clk); #1;
        e.rdata = rdata_exp;
        e.err   = err_exp;
        e.due   = cyc + (use0 ? 0 : 2);
        if (use0) begin
            q0.push_back(e);
            bus0.req_valid = 1'b0; bus0.req_rw = ~rw; bus0.req_addr = addr ^ 32'h5; bus0.req_wdata = ~wdata;
        end else begin
            q2.push_back(e);
            bus2.req_valid = 1'b0; bus2.req_rw = ~rw; bus2.req_addr = addr ^ 32'h5; bus2.req_wdata = ~wdata;
        end
        n = 0; k = 0; ok = 1'b0;
        while (n < 100 && !ok) begin
            @(negedge clk);
            n++;
            if (use0 ? bus0.rsp_valid : bus2.rsp_valid) begin
                if (use0 ? bus0.rsp_ready : bus2.rsp_ready) begin
                    ok = 1'b1;
                end else begin
                    k++;
                    if (k >= hold) begin
                        @(posedge clk); #1;
                        if (use0) bus0.rsp_ready = 1'b1; else bus2.rsp_ready = 1'b1;
                    end
                end
            end
        end
        if (!ok) begin
            tests++; fails++;
            $display("[TB] FAIL rsp_timeout: got no response handshake in 100 cycles, expected one");
            bus0.rsp_ready = 1'b1; bus2.rsp_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check_output("idle_ready_after_resp", 32'(use0 ? bus0.req_ready : bus2.req_ready), 32'd1);
        check_output("idle_no_rsp_after_resp", 32'(use0 ? bus0.rsp_valid : bus2.rsp_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus2.req_valid = 1'b1; bus2.req_rw = 1'b0; bus2.req_addr = 32'd0; bus2.req_wdata = 32'd0; bus2.rsp_ready = 1'b1;
        bus0.req_valid = 1'b1; bus0.req_rw = 1'b0; bus0.req_addr = 32'd0; bus0.req_wdata = 32'd0; bus0.rsp_ready = 1'b1;

        // T1: reset with requests pending, then release
        repeat (2) begin
            @(negedge clk);
            check_output("rst_req_ready", 32'(bus2.req_ready), 32'd0);
            check_output("rst_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
            check_output("rst_rsp_rdata", bus2.rsp_rdata, 32'd0);
            check_output("rst_rsp_err", 32'(bus2.rsp_err), 32'd0);
            check_output("rst_w0_req_ready", 32'(bus0.req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus2.req_valid = 1'b0;
        bus0.req_valid = 1'b0;
        @(negedge clk);
        check_output("rel_req_ready_same_cycle", 32'(bus2.req_ready), 32'd0);
        @(negedge clk);
        check_output("rel_req_ready_next_cycle", 32'(bus2.req_ready), 32'd1);
        check_output("rel_w0_req_ready_next_cycle", 32'(bus0.req_ready), 32'd1);

        // T2: write then read, two wait states
        apply_stimulus(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 32'd0, 1'b0, 0);
        apply_stimulus(1'b0, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 0);

        // T3: zero wait states
        apply_stimulus(1'b1, 1'b1, 32'd0, 32'h12345678, 32'd0, 1'b0, 0);
        apply_stimulus(1'b1, 1'b0, 32'd0, 32'h0, 32'h12345678, 1'b0, 0);

        // T4: backpressure for five response cycles
        apply_stimulus(1'b0, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 5);

        // T5: bounds and no address wrap
        apply_stimulus(1'b0, 1'b1, 32'd199, 32'hA5A50199, 32'd0, 1'b0, 0);
        apply_stimulus(1'b0, 1'b1, 32'd200, 32'd7, 32'd0, BC, 0);
        apply_stimulus(1'b0, 1'b0, 32'd199, 32'h0, 32'hA5A50199, 1'b0, 0);
        apply_stimulus(1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, 32'd0, BC, 0);
        apply_stimulus(1'b0, 1'b0, 32'd200, 32'h0, 32'd0, BC, 0);
        apply_stimulus(1'b0, 1'b1, 32'd261, 32'h00000077, 32'd0, BC, 0);
        apply_stimulus(1'b0, 1'b1, 32'h80000005, 32'h00000088, 32'd0, BC, 0);
        apply_stimulus(1'b0, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 0);

        // T6: reset on the edge that would commit a pending write
        apply_stimulus(1'b0, 1'b1, 32'd3, 32'h00000033, 32'd0, 1'b0, 0);
        @(posedge clk); #1;
        bus2.req_valid = 1'b1; bus2.req_rw = 1'b1; bus2.req_addr = 32'd3; bus2.req_wdata = 32'd9;
        @(negedge clk);
        check_output("t6_ready_before_accept", 32'(bus2.req_ready), 32'd1);
        @(posedge clk); #1;
        bus2.req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_output("t6_rsp_valid_after_reset", 32'(bus2.rsp_valid), 32'd0);
        check_output("t6_ready_low_after_reset", 32'(bus2.req_ready), 32'd0);
        @(negedge clk);
        check_output("t6_idle_ready", 32'(bus2.req_ready), 32'd1);
        apply_stimulus(1'b0, 1'b0, 32'd3, 32'h0, 32'h00000033, 1'b0, 0);

        repeat (5) @(posedge clk);
        check_output("w2_queue_drained", 32'(q2.size()), 32'd0);
        check_output("w0_queue_drained", 32'(q0.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no completion by 200000 time units, expected completion");
        $fatal(1, "[TB] global timeout");
    end
endmodule
